fwrisc_mem_arbiter: RTL

//  Shares the single-port on-chip ROM/RAM word array between three requesters:

---
 rtl/fwrisc_mem_arbiter_pkg.sv | 20 ++
 rtl/fwrisc_mem_arbiter_prio.sv | 57 +++++
 rtl/fwrisc_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fwrisc_mem_arbiter_pkg.sv
// Shared types for the fwrisc memory arbiter: FSM states, grant owner codes
// and the loader byte-enable constant.
package fwrisc_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_LD   = 2'd1,
    GNT_D    = 2'd2,
    GNT_I    = 2'd3
  } arb_gnt_t;

  localparam logic [3:0] LD_WE = 4'hF;

endpackage

// File: rtl/fwrisc_mem_arbiter_prio.sv
// Winner select for the memory arbiter plus the data-burst counter that stops
// a busy data port from starving instruction fetch.
module fwrisc_arb_prio
  import fwrisc_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 4,
  parameter int unsigned CW          = 3
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          arb_en_i,
  input  logic          ld_elig_i,
  input  logic          d_elig_i,
  input  logic          i_elig_i,
  input  logic          i_valid_i,
  output arb_gnt_t      win_o,
  output logic [CW-1:0] burst_cnt_o
);

  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_D_BURST);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          force_i;

  // Loader and core eligibility are mutually exclusive, so forcing instr
  // ahead of data never overrides the loader.
  assign force_i = i_elig_i && (burst_cnt_q == BURST_MAX);

  always_comb begin
    win_o = GNT_NONE;
    if (arb_en_i) begin
      if (ld_elig_i)     win_o = GNT_LD;
      else if (force_i)  win_o = GNT_I;
      else if (d_elig_i) win_o = GNT_D;
      else if (i_elig_i) win_o = GNT_I;
    end
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (arb_en_i) begin
      if (win_o == GNT_I || !i_valid_i) begin
        burst_cnt_d = '0;
      end else if (win_o == GNT_D && burst_cnt_q != BURST_MAX) begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) burst_cnt_q <= '0;
    else        burst_cnt_q <= burst_cnt_d;
  end

  assign burst_cnt_o = burst_cnt_q;

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Shares the single-port sync-read memory between the UART loader, core data
// port and core instruction port; one access every three cycles.
module fwrisc_mem_arbiter
  import fwrisc_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 12,
  parameter logic [3:0]  MEM_NIB     = 4'h8,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          boot_active_i,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_wdata_i,
  output logic          ld_ready_o,
  input  logic          i_valid_i,
  input  logic [31:0]   i_addr_i,
  output logic          i_ready_o,
  output logic [31:0]   i_rdata_o,
  input  logic          d_valid_i,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_wdata_i,
  input  logic [3:0]    d_strb_i,
  input  logic          d_write_i,
  output logic          d_ready_o,
  output logic [31:0]   d_rdata_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic [1:0]    grant_o,
  output arb_state_t    dbg_state_o,
  output logic [$clog2(MAX_D_BURST+1)-1:0] dbg_burst_cnt_o
);

  localparam int unsigned CW = $clog2(MAX_D_BURST + 1);

  // Handshake: a requester raises valid with stable address/data and holds it
  // until its ready pulses for exactly one cycle; requests are sampled only in
  // IDLE, so changes during ISSUE/RESP are never seen.

  arb_state_t    state_q, state_d;
  arb_gnt_t      gnt_q, gnt_d, win;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    we_q, we_d;
  logic          rd_q, rd_d;
  logic          load_cmd;
  logic          ld_elig, d_elig, i_elig;
  logic          issue, resp;
  logic          unused_addr_bits;

  assign ld_elig = boot_active_i && ld_valid_i;
  assign d_elig  = !boot_active_i && d_valid_i && (d_addr_i[31:28] == MEM_NIB);
  assign i_elig  = !boot_active_i && i_valid_i;

  fwrisc_arb_prio #(
    .MAX_D_BURST (MAX_D_BURST),
    .CW          (CW)
  ) u_prio (
    .clock       (clock),
    .rst_n       (rst_n),
    .arb_en_i    (state_q == ARB_IDLE),
    .ld_elig_i   (ld_elig),
    .d_elig_i    (d_elig),
    .i_elig_i    (i_elig),
    .i_valid_i   (i_valid_i),
    .win_o       (win),
    .burst_cnt_o (dbg_burst_cnt_o)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    load_cmd = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        gnt_d = GNT_NONE;
        if (win != GNT_NONE) begin
          state_d  = ARB_ISSUE;
          gnt_d    = win;
          load_cmd = 1'b1;
        end
      end
      ARB_ISSUE: state_d = ARB_RESP;
      ARB_RESP: begin
        state_d = ARB_IDLE;
        gnt_d   = GNT_NONE;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd_d    = rd_q;
    if (load_cmd) begin
      case (win)
        GNT_LD: begin
          addr_d  = ld_addr_i;
          wdata_d = ld_wdata_i;
          we_d    = LD_WE;
          rd_d    = 1'b0;
        end
        GNT_D: begin
          addr_d  = d_addr_i[AW+1:2];
          wdata_d = d_write_i ? d_wdata_i : 32'h0;
          we_d    = d_write_i ? d_strb_i : 4'h0;
          rd_d    = !d_write_i;
        end
        GNT_I: begin
          addr_d  = i_addr_i[AW+1:2];
          wdata_d = 32'h0;
          we_d    = 4'h0;
          rd_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
    end
  end

  assign issue = (state_q == ARB_ISSUE);
  assign resp  = (state_q == ARB_RESP);

  assign mem_en_o    = issue;
  assign mem_we_o    = issue ? we_q : 4'h0;
  assign mem_addr_o  = issue ? addr_q : '0;
  assign mem_wdata_o = issue ? wdata_q : 32'h0;

  assign ld_ready_o = resp && (gnt_q == GNT_LD);
  assign d_ready_o  = resp && (gnt_q == GNT_D);
  assign i_ready_o  = resp && (gnt_q == GNT_I);
  assign d_rdata_o  = (d_ready_o && rd_q) ? mem_rdata_i : 32'h0;
  assign i_rdata_o  = i_ready_o ? mem_rdata_i : 32'h0;

  assign grant_o     = gnt_q;
  assign dbg_state_o = state_q;

  // Out-of-window byte-address bits alias onto the same word.
  assign unused_addr_bits = ^{i_addr_i[31:AW+2], i_addr_i[1:0],
                              d_addr_i[27:AW+2], d_addr_i[1:0]};

endmodule
